// File: rtl/run_pattern_gen_pkg.sv
// Shared types and helpers for the run-length pattern generator.
// Run k of a packed run-length vector sits at bits [k*w +: w].
package rpg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam int DEF_LEN_W    = 4;
  localparam int DEF_NUM_RUNS = 4;
  localparam int MAX_PACKED_W = 256;

  function automatic logic [31:0] run_len_at(input logic [MAX_PACKED_W-1:0] rl_vec,
                                             input int k, input int w);
    logic [MAX_PACKED_W-1:0] s;
    s = rl_vec >> (k * w);
    return s[31:0] & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/run_pattern_gen_if.sv
// Request/config inputs and serial outputs of the pattern generator.
// The master side requests frames; the slave side is the generator.
interface run_pattern_gen_if import rpg_pkg::*; #(
  parameter int LEN_W    = DEF_LEN_W,
  parameter int NUM_RUNS = DEF_NUM_RUNS
) ();

  logic                      START;
  logic                      FIRST_BIT;
  logic [NUM_RUNS*LEN_W-1:0] RUN_LEN;
  logic                      OUT;
  logic                      OUT_VALID;
  logic                      BUSY;
  logic                      DONE;
  logic                      ERR;

  modport master (
    output START, FIRST_BIT, RUN_LEN,
    input  OUT, OUT_VALID, BUSY, DONE, ERR
  );

  modport slave (
    input  START, FIRST_BIT, RUN_LEN,
    output OUT, OUT_VALID, BUSY, DONE, ERR
  );

endinterface

// File: rtl/run_pattern_gen_run_len_counter.sv
// Loadable down-counter for the length of the current run.
// last_o flags the final bit of the run (count == 1); load wins over enable.
module run_len_counter import rpg_pkg::*; #(
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [LEN_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             last_o
);

  logic [LEN_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (en_i)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/run_pattern_gen.sv
// Serial transmitter of NUM_RUNS alternating runs; bit 0 is driven the cycle after START is sampled.
// All outputs registered; START and config are ignored outside IDLE.
module run_pattern_gen import rpg_pkg::*; #(
  parameter int LEN_W    = DEF_LEN_W,
  parameter int NUM_RUNS = DEF_NUM_RUNS
) (
  input  logic              CLK,
  input  logic              RESET,
  run_pattern_gen_if.slave  bus
);

  localparam int IDX_W = (NUM_RUNS > 1) ? $clog2(NUM_RUNS) : 1;
  localparam int RL_W  = NUM_RUNS * LEN_W;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              first_q, first_d;
  logic [RL_W-1:0]   run_len_q, run_len_d;
  logic              out_q, out_d;
  logic              vld_q, vld_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              cnt_load, cnt_en, cnt_last;
  logic [LEN_W-1:0]  cnt_load_val, next_len, first_len;
  logic [IDX_W-1:0]  next_idx;
  logic              last_run, any_zero;

  run_len_counter #(.LEN_W(LEN_W)) u_cnt (
    .clk        (CLK),
    .rst        (RESET),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .en_i       (cnt_en),
    .last_o     (cnt_last)
  );

  always_comb begin
    any_zero = 1'b0;
    for (int k = 0; k < NUM_RUNS; k++)
      if (run_len_at(MAX_PACKED_W'(bus.RUN_LEN), k, LEN_W) == 32'd0)
        any_zero = 1'b1;
  end

  assign next_idx  = idx_q + 1'b1;
  assign last_run  = (int'(idx_q) == NUM_RUNS - 1);
  assign next_len  = LEN_W'(run_len_at(MAX_PACKED_W'(run_len_q), int'(next_idx), LEN_W));
  assign first_len = LEN_W'(run_len_at(MAX_PACKED_W'(bus.RUN_LEN), 0, LEN_W));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    first_d      = first_q;
    run_len_d    = run_len_q;
    out_d        = 1'b0;
    vld_d        = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = next_len;
    cnt_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          if (any_zero) begin
            err_d = 1'b1;
          end else begin
            state_d      = SEND;
            idx_d        = '0;
            first_d      = bus.FIRST_BIT;
            run_len_d    = bus.RUN_LEN;
            cnt_load     = 1'b1;
            cnt_load_val = first_len;
            out_d        = bus.FIRST_BIT;
            vld_d        = 1'b1;
          end
        end
      end
      SEND: begin
        if (!cnt_last) begin
          cnt_en = 1'b1;
          out_d  = out_q;
          vld_d  = 1'b1;
        end else if (!last_run) begin
          // Run boundary: next run starts on this same edge, so no gap bit.
          idx_d    = next_idx;
          cnt_load = 1'b1;
          out_d    = first_q ^ next_idx[0];
          vld_d    = 1'b1;
        end else begin
          state_d = FIN;
          done_d  = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      first_q   <= 1'b0;
      run_len_q <= '0;
      out_q     <= 1'b0;
      vld_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      first_q   <= first_d;
      run_len_q <= run_len_d;
      out_q     <= out_d;
      vld_q     <= vld_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.OUT       = out_q;
  assign bus.OUT_VALID = vld_q;
  assign bus.BUSY      = vld_q;
  assign bus.DONE      = done_q;
  assign bus.ERR       = err_q;

endmodule

// File: tb/tb_run_pattern_gen.sv
// Directed and randomized frames checked against a queue-based model of the run stream.
module tb_run_pattern_gen;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  run_pattern_gen_if #(.LEN_W(4), .NUM_RUNS(4)) bus ();

  run_pattern_gen #(.LEN_W(4), .NUM_RUNS(4)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {OUT, OUT_VALID, BUSY, DONE, ERR} all low
  task automatic check_idle(input string tag);
    check(tag, 32'({bus.OUT, bus.OUT_VALID, bus.BUSY, bus.DONE, bus.ERR}), 32'd0);
  endtask

  function automatic logic [15:0] pack4(input int a, input int b, input int c, input int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  // Called at a negedge in IDLE; returns at the negedge after the sampling edge.
  task automatic start(input logic fb, input logic [15:0] rl);
    bus.START     = 1'b1;
    bus.FIRST_BIT = fb;
    bus.RUN_LEN   = rl;
    @(negedge clk);
    bus.START = 1'b0;
  endtask

  // Model: run k contributes len_k copies of fb^(k odd); then exactly one DONE cycle.
  task automatic expect_frame(input logic fb, input logic [15:0] rl, input string tag, input bit chg);
    bit q[$];
    for (int k = 0; k < 4; k++) begin
      int unsigned len;
      len = int'((rl >> (4 * k)) & 16'hF);
      for (int j = 0; j < int'(len); j++) q.push_back(fb ^ (k % 2 == 1));
    end
    foreach (q[i]) begin
      check({tag, "/bit"}, 32'({bus.OUT, bus.OUT_VALID, bus.BUSY, bus.DONE, bus.ERR}),
            32'({q[i], 4'b1100}));
      if (chg && i == 2) begin
        bus.RUN_LEN   = 16'h1111;
        bus.FIRST_BIT = ~fb;
      end
      @(negedge clk);
    end
    check({tag, "/done"}, 32'({bus.OUT, bus.OUT_VALID, bus.BUSY, bus.DONE, bus.ERR}), 32'b00010);
  endtask

  initial begin
    logic        fb;
    logic [15:0] rl;
    int          l[4];

    rst           = 1'b1;
    bus.START     = 1'b0;
    bus.FIRST_BIT = 1'b0;
    bus.RUN_LEN   = '0;
    #1 check_idle("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_idle("idle");
    end

    start(1'b0, pack4(1, 1, 1, 1));
    expect_frame(1'b0, pack4(1, 1, 1, 1), "basic", 1'b0);
    @(negedge clk); check_idle("basic_after");

    start(1'b1, pack4(3, 2, 15, 1));
    expect_frame(1'b1, pack4(3, 2, 15, 1), "long", 1'b0);
    @(negedge clk); check_idle("long_after");

    bus.START   = 1'b1;
    bus.RUN_LEN = pack4(1, 1, 0, 1);
    @(negedge clk);
    bus.START = 1'b0;
    check("zero_err", 32'({bus.OUT_VALID, bus.BUSY, bus.DONE, bus.ERR}), 32'b0001);
    @(negedge clk); check_idle("zero_err_pulse");
    @(negedge clk); check_idle("zero_still_idle");

    // START held high across a frame; config changes mid-frame must not matter.
    start(1'b0, pack4(2, 2, 2, 2));
    bus.START = 1'b1;
    expect_frame(1'b0, pack4(2, 2, 2, 2), "hold", 1'b1);
    @(negedge clk); check_idle("hold_gap");
    @(negedge clk);
    bus.START = 1'b0;
    expect_frame(1'b1, 16'h1111, "hold2", 1'b0);
    @(negedge clk); check_idle("hold2_after");

    start(1'b1, pack4(2, 2, 2, 2));
    repeat (4) @(negedge clk);
    check("pre_rst_bit", 32'({bus.OUT, bus.OUT_VALID}), 32'b11);
    #2 rst = 1'b1;
    #1 check("async_rst", 32'({bus.OUT, bus.OUT_VALID, bus.BUSY, bus.DONE}), 32'd0);
    @(negedge clk); check_idle("rst_hold");
    rst = 1'b0;
    @(negedge clk); check_idle("rst_release");
    start(1'b0, pack4(3, 1, 2, 4));
    expect_frame(1'b0, pack4(3, 1, 2, 4), "post_rst", 1'b0);
    @(negedge clk); check_idle("post_rst_after");

    for (int it = 0; it < 9; it++) begin
      fb = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) l[k] = int'($urandom_range(1, 15));
      if (it % 3 == 2) l[$urandom_range(0, 3)] = 0;
      rl = pack4(l[0], l[1], l[2], l[3]);
      @(negedge clk);
      start(fb, rl);
      if (l[0] == 0 || l[1] == 0 || l[2] == 0 || l[3] == 0) begin
        check("rand_err", 32'({bus.OUT, bus.OUT_VALID, bus.BUSY, bus.DONE, bus.ERR}), 32'b00001);
      end else begin
        expect_frame(fb, rl, "rand", 1'b0);
      end
      @(negedge clk); check_idle("rand_after");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/run_pattern_gen.md
Name: run_pattern_gen

Overview:
- Serial run-length pattern transmitter. On a start request it emits a bit stream of NUM_RUNS alternating runs: run 0 has value FIRST_BIT, each later run inverts the previous value, and run k is RUN_LEN[k] bits long.
- It is the driving end of our serial sequence detectors. With 4 runs it produces exactly the 0+1+0+1 / 1+0+1+0 streams the detector FSM must flag.
- Used as the stimulus source in detector integration and as a self-test pattern source on the serial line.

Parameters:
- LEN_W, 4, width of each run-length field; max run = 2^LEN_W-1 bits
- NUM_RUNS, 4, number of alternating runs per frame (>=1)

Ports:
- CLK  input  1  clock; all state changes on rising edge
- RESET  input  1  asynchronous, active-high reset
- START  input  1  frame request, sampled only in IDLE
- FIRST_BIT  input  1  value of run 0; captured at START
- RUN_LEN  input  NUM_RUNS*LEN_W  packed run lengths, run k at bits [k*LEN_W +: LEN_W]; captured at START
- OUT  output  1  serial data bit
- OUT_VALID  output  1  OUT carries a frame bit this cycle
- BUSY  output  1  frame in progress (equals OUT_VALID)
- DONE  output  1  one-cycle pulse after the last bit
- ERR  output  1  one-cycle pulse: START rejected because a run length was 0

Behaviour:
- Reset (async, immediate): state=IDLE; OUT=0, OUT_VALID=0, BUSY=0, DONE=0, ERR=0; captured config cleared. Reset mid-frame aborts the frame with no DONE.
- All outputs are registered.
- States: IDLE, SEND, FIN. FIN is a single cycle.
- IDLE:
  - START=1 with all RUN_LEN fields nonzero: capture FIRST_BIT and RUN_LEN; run index=0; load run counter with RUN_LEN[0]; go to SEND.
  - START=1 with any RUN_LEN field =0: ERR=1 for one cycle; stay in IDLE; outputs otherwise unchanged.
  - START=0: stay. OUT=0, OUT_VALID=0.
- Latency: the edge E0 that samples START moves to SEND. Bit 0 is valid from E0 to E1. Bit i is valid from Ei to Ei+1. There are no gaps between bits.
- SEND:
  - OUT = FIRST_BIT XOR (run index odd); OUT_VALID=1; BUSY=1.
  - Each edge decrements the run counter.
  - When the counter reaches its last bit and the run index < NUM_RUNS-1: increment the index, reload the counter with the next RUN_LEN, and OUT toggles on the same edge.
  - On the last bit of the last run: go to FIN.
- FIN: OUT=0, OUT_VALID=0, BUSY=0, DONE=1 for exactly one cycle, then IDLE.
- Back-to-back: START sampled in FIN is ignored. A new frame can start on the edge after FIN. Minimum inter-frame gap is 2 cycles (FIN + IDLE).
- START, FIRST_BIT and RUN_LEN changes while in SEND or FIN are ignored; the captured copies are used.
- Frame length N = sum of RUN_LEN. OUT_VALID is high for exactly N cycles. Max N = NUM_RUNS*(2^LEN_W-1). The run counter is LEN_W bits and needs no wrap handling.
- NUM_RUNS=1: a single run, no toggle.

Decomposition:
- Shared package rpg_pkg:
  - state enum {IDLE, SEND, FIN}
  - default LEN_W / NUM_RUNS constants
  - function to extract run k from the packed RUN_LEN
- Natural sub-module: run_len_counter. It is a loadable LEN_W down-counter with a load input, an enable, and a "last" flag (count==1).
- Top level keeps the FSM, run index, captured config and output registers.

Test Plan:
- Reset then idle: RESET pulse, START=0 for 5 cycles -> OUT=0, OUT_VALID=0, BUSY=0, DONE=0, ERR=0 throughout.
- Basic frame: FIRST_BIT=0, RUN_LEN={1,1,1,1} -> OUT_VALID high 4 cycles, OUT=0,1,0,1 starting the cycle after the START edge, then DONE=1 for 1 cycle. Loop-back check: the detector FSM, held in reset through the START edge and fed OUT, raises its output on the edge sampling bit 3.
- Long runs: FIRST_BIT=1, RUN_LEN={3,2,15,1} -> OUT=111 00 1x15 0, OUT_VALID exactly 21 cycles, DONE on the 22nd.
- Zero-length reject: RUN_LEN[2]=0 with START=1 -> ERR=1 for one cycle; state stays IDLE; OUT_VALID stays 0.
- Ignore START while busy: START held high throughout a {2,2,2,2} frame, with RUN_LEN changed mid-frame -> the frame is unchanged (8 bits). After DONE, IDLE samples START and a second frame begins 2 cycles after the last bit of the first.
- Async reset mid-frame: RESET asserted between clock edges during run 2 -> OUT and OUT_VALID drop to 0 immediately, no DONE; a later START produces a complete, correct frame.
